dac_multi_model: RTL and testbench

- Parametrised, multi-channel behavioural DAC model for the sine-wave benches; next generation of the single-channel 8-bit DAC.
- Accepts codes through a valid/ready write port into per-channel input registers.
- Transfers them to the DAC registers either immediately (auto mode) or together on an LDAC strobe, then slews each output code toward its target.
- Presents each channel as a packed code and a real-valued voltage for analysis and checking.

---
 rtl/dac_multi_pkg.sv | 43 ++++
 rtl/dac_slew_chan.sv | 39 +++
 rtl/dac_multi_model.sv | 103 ++++++++++
 tb/tb_dac_multi_model.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_multi_pkg.sv
// Shared types and helpers for the multi-channel DAC model.
// Holds the FSM encoding, code-to-voltage and slew arithmetic.
package dac_multi_pkg;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } state_e;

    // Codes are carried zero-extended to 16 bits, the widest supported.
    function automatic real code_to_volt(
        input logic [15:0] code,
        input int          width,
        input real         vref,
        input bit          bipolar
    );
        real full;
        real half;
        full = real'(32'd1 << width);
        half = full / 2.0;
        if (bipolar)
            return vref * (real'(code) - half) / half;
        return vref * real'(code) / full;
    endfunction

    // One slew step toward tgt; never overshoots and never wraps.
    function automatic logic [15:0] slew_next(
        input logic [15:0] cur,
        input logic [15:0] tgt,
        input int          step
    );
        logic signed [16:0] d;
        logic signed [16:0] mag;
        d   = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        mag = (d < 0) ? -d : d;
        if (step == 0 || int'(mag) <= step)
            return tgt;
        if (d > 0)
            return cur + 16'(step);
        return cur - 16'(step);
    endfunction

endpackage

// File: rtl/dac_slew_chan.sv
// One DAC channel: target register plus slew-limited output code.
// settled is high whenever the output has reached its target.
module dac_slew_chan
    import dac_multi_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SLEW_STEP  = 0,
    parameter int RESET_CODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_code,
    output logic [WIDTH-1:0] out_code,
    output logic             settled
);

    logic [WIDTH-1:0] dac_reg;

    // Target register, loaded by a write (auto) or a transfer (ldac).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dac_reg <= WIDTH'(RESET_CODE);
        else if (load)
            dac_reg <= load_code;
    end

    // Output ramps toward the target as it stood before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_code <= WIDTH'(RESET_CODE);
        else
            out_code <= WIDTH'(slew_next(16'(out_code), 16'(dac_reg),
                                         SLEW_STEP));
    end

    assign settled = (out_code == dac_reg);

endmodule

// File: rtl/dac_multi_model.sv
// Multi-channel behavioural DAC: write port, input registers, LDAC FSM.
// Each channel's target and ramp live in a dac_slew_chan instance.
module dac_multi_model
    import dac_multi_pkg::*;
#(
    parameter int  WIDTH       = 8,
    parameter int  CHANNELS    = 4,
    parameter real VREF        = 3.3,
    parameter int  BIPOLAR     = 0,
    parameter int  AUTO_UPDATE = 0,
    parameter int  SLEW_STEP   = 0,
    parameter int  RESET_CODE  = 0,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CW-1:0]             in_ch,
    input  logic [WIDTH-1:0]          in_code,
    input  logic                      ldac,
    output logic                      err,
    output logic [CHANNELS*WIDTH-1:0] out_code,
    output real                       a_out [CHANNELS],
    output logic [CHANNELS-1:0]       settled
);

    state_e           state;
    logic             up;
    logic             accept;
    logic             ch_ok;
    logic [WIDTH-1:0] input_reg [CHANNELS];
    logic [CHANNELS-1:0] wr_hit;
    logic [CHANNELS-1:0] ld;
    logic [WIDTH-1:0] ld_code [CHANNELS];

    assign in_ready = up && (state == S_IDLE);
    assign accept   = in_valid && in_ready;
    assign ch_ok    = int'(in_ch) < CHANNELS;

    // Ready comes up one edge after reset; ldac opens a one-cycle transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up    <= 1'b0;
            state <= S_IDLE;
        end else begin
            up <= 1'b1;
            unique case (state)
                S_IDLE:
                    if (ldac && up && AUTO_UPDATE == 0)
                        state <= S_XFER;
                S_XFER:
                    state <= S_IDLE;
                default:
                    state <= S_IDLE;
            endcase
        end
    end

    // Accepted writes to an existing channel land in its input register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++)
                input_reg[c] <= WIDTH'(RESET_CODE);
        end else begin
            for (int c = 0; c < CHANNELS; c++)
                if (accept && ch_ok && int'(in_ch) == c)
                    input_reg[c] <= in_code;
        end
    end

    // A write to a missing channel is dropped and flagged for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err <= 1'b0;
        else
            err <= accept && !ch_ok;
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign wr_hit[c]  = accept && ch_ok && (int'(in_ch) == c);
        assign ld[c]      = (AUTO_UPDATE != 0) ? wr_hit[c]
                                               : (state == S_XFER);
        assign ld_code[c] = (AUTO_UPDATE != 0) ? in_code : input_reg[c];

        dac_slew_chan #(
            .WIDTH      (WIDTH),
            .SLEW_STEP  (SLEW_STEP),
            .RESET_CODE (RESET_CODE)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (ld[c]),
            .load_code (ld_code[c]),
            .out_code  (out_code[c*WIDTH +: WIDTH]),
            .settled   (settled[c])
        );

        assign a_out[c] = code_to_volt(16'(out_code[c*WIDTH +: WIDTH]),
                                       WIDTH, VREF, BIPOLAR != 0);
    end

endmodule

// File: tb/tb_dac_multi_model.sv
// Bench for dac_multi_model: four configurations share one stimulus bus.
// sel routes in_valid/ldac to one instance; outputs checked per instance.
module tb_dac_multi_model;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       ldac;
    logic [1:0] in_ch;
    logic [7:0] in_code;
    int         sel;

    logic [3:0] v;
    logic [3:0] l;
    logic [3:0] rdy;
    logic [3:0] err;

    logic [31:0] oc0, oc1, oc2;
    logic [23:0] oc3;
    real         a0 [4];
    real         a1 [4];
    real         a2 [4];
    real         a3 [3];
    logic [3:0]  st0, st1, st2;
    logic [2:0]  st3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string tag;
        int    val;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    assign v = in_valid ? (4'b1 << sel) : 4'b0;
    assign l = ldac ? (4'b1 << sel) : 4'b0;

    // 0: ldac mode, 1: auto unipolar, 2: auto bipolar, 3: auto slew, 3 ch
    dac_multi_model #(.AUTO_UPDATE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v[0]), .in_ready(rdy[0]),
        .in_ch(in_ch), .in_code(in_code), .ldac(l[0]), .err(err[0]),
        .out_code(oc0), .a_out(a0), .settled(st0));

    dac_multi_model #(.AUTO_UPDATE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v[1]), .in_ready(rdy[1]),
        .in_ch(in_ch), .in_code(in_code), .ldac(l[1]), .err(err[1]),
        .out_code(oc1), .a_out(a1), .settled(st1));

    dac_multi_model #(.AUTO_UPDATE(1), .BIPOLAR(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v[2]), .in_ready(rdy[2]),
        .in_ch(in_ch), .in_code(in_code), .ldac(l[2]), .err(err[2]),
        .out_code(oc2), .a_out(a2), .settled(st2));

    dac_multi_model #(.CHANNELS(3), .AUTO_UPDATE(1), .SLEW_STEP(16)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(v[3]), .in_ready(rdy[3]),
        .in_ch(in_ch), .in_code(in_code), .ldac(l[3]), .err(err[3]),
        .out_code(oc3), .a_out(a3), .settled(st3));

    function automatic int code(int k, int c);
        case (k)
            0:       return int'(oc0[c*8 +: 8]);
            1:       return int'(oc1[c*8 +: 8]);
            2:       return int'(oc2[c*8 +: 8]);
            default: return int'(oc3[c*8 +: 8]);
        endcase
    endfunction

    // Voltage in units of 100 uV, rounded.
    function automatic int volt(int k, int c);
        case (k)
            0:       return int'(a0[c] * 10000.0);
            1:       return int'(a1[c] * 10000.0);
            2:       return int'(a2[c] * 10000.0);
            default: return int'(a3[c] * 10000.0);
        endcase
    endfunction

    task automatic chk(string tag, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic push(string tag, int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sbq.push_back(e);
    endtask

    task automatic pop(int got);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty got %0d exp none", got);
        end else begin
            e = sbq.pop_front();
            chk(e.tag, got, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the accepting edge.
    task automatic wr(int k, int ch, int cd);
        logic r;
        bit   ok;
        ok       = 1'b0;
        sel      = k;
        in_ch    = 2'(ch);
        in_code  = 8'(cd);
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            r = rdy[k];
            tick();
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok)
            chk("wr_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout got 0 exp 1");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        ldac     = 1'b0;
        sel      = 0;
        in_ch    = 2'd0;
        in_code  = 8'h55;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", int'(rdy[0]), 0);
        for (int c = 0; c < 4; c++) begin
            chk("rst_code", code(0, c), 0);
            chk("rst_volt", volt(0, c), 0);
        end
        chk("rst_st", int'(st0), 15);
        chk("bip_rst_volt", volt(2, 0), -33000);
        #3;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rel_rdy0", int'(rdy[0]), 0);
        tick();
        chk("rel_rdy1", int'(rdy[0]), 1);

        // ldac-mode: write parks in the input register
        wr(0, 1, 8'h80);
        for (int i = 0; i < 3; i++) begin
            chk("ldac_hold", code(0, 1), 0);
            tick();
        end
        sel  = 0;
        ldac = 1'b1;
        push("ldac_n1", 0);
        push("ldac_n2", 128);
        tick();
        ldac = 1'b0;
        chk("xfer_rdy", int'(rdy[0]), 0);
        tick();
        pop(code(0, 1));
        chk("xfer_rdy_back", int'(rdy[0]), 1);
        tick();
        pop(code(0, 1));
        chk("ldac_volt", volt(0, 1), 16500);

        // simultaneous write + ldac; ldac held into S_XFER is not queued
        wr(0, 2, 8'h33);
        chk("pend_ch2", code(0, 2), 0);
        sel      = 0;
        in_ch    = 2'd0;
        in_code  = 8'h40;
        in_valid = 1'b1;
        ldac     = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        ldac = 1'b0;
        chk("xfer_noqueue", int'(rdy[0]), 1);
        push("sim_ch0", 8'h40);
        push("sim_ch1", 8'h80);
        push("sim_ch2", 8'h33);
        push("sim_ch3", 0);
        tick();
        for (int c = 0; c < 4; c++)
            pop(code(0, c));

        // auto mode, full scale
        wr(1, 3, 8'hFF);
        chk("auto_n0", code(1, 3), 0);
        tick();
        chk("auto_n1", code(1, 3), 255);
        chk("auto_fs_volt", volt(1, 3), 32871);
        sel  = 1;
        ldac = 1'b1;
        tick();
        ldac = 1'b0;
        chk("auto_ldac_rdy", int'(rdy[1]), 1);

        // bipolar
        wr(2, 0, 8'h80);
        tick();
        chk("bip_mid_volt", volt(2, 0), 0);
        wr(2, 1, 8'hC0);
        tick();
        chk("bip_q3_volt", volt(2, 1), 16500);
        chk("bip_zero_volt", volt(2, 2), -33000);

        // slew ramp up
        wr(3, 2, 8'hFF);
        chk("slew_n0", code(3, 2), 0);
        chk("slew_st0", int'(st3[2]), 0);
        for (int i = 1; i <= 16; i++)
            push("slew_up", (i < 16) ? 16 * i : 255);
        for (int i = 1; i <= 16; i++) begin
            tick();
            pop(code(3, 2));
            chk("slew_st", int'(st3[2]), (i == 16) ? 1 : 0);
        end

        // ramp down, reversed mid-ramp
        wr(3, 2, 8'h00);
        chk("rev_a", code(3, 2), 255);
        push("rev_dn", 239);
        push("rev_dn", 223);
        push("rev_turn", 207);
        push("rev_up", 223);
        push("rev_up", 239);
        push("rev_up", 255);
        tick();
        pop(code(3, 2));
        tick();
        pop(code(3, 2));
        wr(3, 2, 8'hFF);
        pop(code(3, 2));
        for (int i = 0; i < 3; i++) begin
            tick();
            pop(code(3, 2));
        end
        chk("rev_settled", int'(st3[2]), 1);

        // write to a missing channel
        chk("err_idle", int'(err[3]), 0);
        wr(3, 3, 8'h11);
        chk("err_pulse", int'(err[3]), 1);
        chk("err_ch0", code(3, 0), 0);
        chk("err_ch1", code(3, 1), 0);
        chk("err_ch2", code(3, 2), 255);
        tick();
        chk("err_clear", int'(err[3]), 0);
        chk("err_ch2_b", code(3, 2), 255);

        // reset while in S_XFER
        sel  = 0;
        ldac = 1'b1;
        tick();
        ldac = 1'b0;
        chk("pre_rst_xfer", int'(rdy[0]), 0);
        #2;
        rst_n = 1'b0;
        #1;
        for (int c = 0; c < 4; c++)
            chk("xrst_code", code(0, c), 0);
        chk("xrst_rdy", int'(rdy[0]), 0);
        chk("xrst_ch2", code(3, 2), 0);
        chk("xrst_st3", int'(st3), 7);
        #3;
        rst_n = 1'b1;
        tick();
        sel  = 0;
        ldac = 1'b1;
        tick();
        ldac = 1'b0;
        tick();
        tick();
        chk("xrst_inreg", code(0, 1), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
